can_tx_mailbox: RTL and testbench

CAN_TX_MAILBOX -- requirements
Module: can_tx_mailbox

---
 rtl/can_pkg.sv | 23 ++
 rtl/can_mbox_prio_sel.sv | 28 ++
 rtl/can_tx_mailbox.sv | 181 ++++++++++++++++++
 tb/tb_can_tx_mailbox.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, mailbox FSM states and the
// arbitration key used to order pending transmit mailboxes.
package can_pkg;
  localparam int CAN_ID_STD_W  = 11;
  localparam int CAN_ID_EXT_W  = 29;
  localparam int CAN_DLC_W     = 4;
  localparam int CAN_DATA_W    = 64;
  localparam int CAN_ARB_KEY_W = 32;

  typedef enum logic [1:0] {IDLE, SELECT, REQ, WAIT} mb_state_e;

  // Bit order mirrors the on-bus arbitration field, so a plain unsigned
  // compare gives bus priority (lower key wins).
  function automatic logic [CAN_ARB_KEY_W-1:0] can_arb_key(
    input logic                    ide,
    input logic                    rtr,
    input logic [CAN_ID_STD_W-1:0] id_std,
    input logic [CAN_ID_EXT_W-1:0] id_ext
  );
    if (ide) can_arb_key = {id_ext[28:18], 1'b1, 1'b1, id_ext[17:0], rtr};
    else     can_arb_key = {id_std, rtr, 1'b0, 18'b0, 1'b0};
  endfunction
endpackage

// File: rtl/can_mbox_prio_sel.sv
// Combinational lowest-key picker over pending mailboxes; ties go to the
// lowest index.
module can_mbox_prio_sel
  import can_pkg::*;
#(
  parameter  int NUM_MB = 4,
  localparam int IDX_W  = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0]                    i_req,
  input  logic [NUM_MB-1:0][CAN_ARB_KEY_W-1:0] i_key,
  output logic                                 o_any,
  output logic [IDX_W-1:0]                     o_idx
);
  logic [CAN_ARB_KEY_W-1:0] w_best;

  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_best = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (i_req[i] && (!o_any || i_key[i] < w_best)) begin
        o_any  = 1'b1;
        o_idx  = IDX_W'(i);
        w_best = i_key[i];
      end
    end
  end
endmodule

// File: rtl/can_tx_mailbox.sv
// CAN transmit mailbox bank: host writes frames, FSM hands the best-priority
// pending frame to the transmitter. CAN_MBOX_RETRY_LIMIT_EN enables the retry limit.
module can_tx_mailbox
  import can_pkg::*;
#(
  parameter  int NUM_MB    = 4,
  parameter  int MAX_RETRY = 8,
  localparam int IDX_W     = $clog2(NUM_MB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_ide,
  input  logic              wr_rtr,
  input  logic [10:0]       wr_id_std,
  input  logic [28:0]       wr_id_ext,
  input  logic [3:0]        wr_dlc,
  input  logic [63:0]       wr_data,
  input  logic              abort_en,
  input  logic [IDX_W-1:0]  abort_idx,
  output logic              start_tx,
  output logic              ide,
  output logic              rtr,
  output logic [10:0]       id_std,
  output logic [28:0]       id_ext,
  output logic [3:0]        dlc,
  output logic [63:0]       tx_data,
  input  logic              tx_done,
  input  logic              arb_lost,
  input  logic              tx_error,
  output logic [NUM_MB-1:0] mb_pending,
  output logic              wr_err,
  output logic              done_pulse,
  output logic              fail_pulse,
  output logic [IDX_W-1:0]  evt_idx
);
  mb_state_e r_state, w_state_nxt;

  logic        r_mb_ide    [NUM_MB];
  logic        r_mb_rtr    [NUM_MB];
  logic [10:0] r_mb_id_std [NUM_MB];
  logic [28:0] r_mb_id_ext [NUM_MB];
  logic [3:0]  r_mb_dlc    [NUM_MB];
  logic [63:0] r_mb_data   [NUM_MB];

  logic [NUM_MB-1:0] r_pending, r_abort;
  logic [IDX_W-1:0]  r_cur, r_evt;
  logic              r_wr_err, r_done, r_fail;
  logic              r_ide, r_rtr;
  logic [10:0]       r_id_std;
  logic [28:0]       r_id_ext;
  logic [3:0]        r_dlc;
  logic [63:0]       r_data;

  logic [NUM_MB-1:0][CAN_ARB_KEY_W-1:0] w_keys;
  logic             w_any, w_sel_ok, w_busy, w_wr_ok, w_abort_cur;
  logic [IDX_W-1:0] w_win;
  logic             w_done, w_err, w_lost, w_outcome, w_retry_hit, w_release;

  always_comb begin
    for (int i = 0; i < NUM_MB; i++)
      w_keys[i] = can_arb_key(r_mb_ide[i], r_mb_rtr[i], r_mb_id_std[i], r_mb_id_ext[i]);
  end

  can_mbox_prio_sel #(.NUM_MB(NUM_MB)) u_sel (
    .i_req (r_pending),
    .i_key (w_keys),
    .o_any (w_any),
    .o_idx (w_win)
  );

  assign w_busy      = (r_state == REQ) || (r_state == WAIT);
  assign w_wr_ok     = wr_en && !(w_busy && wr_idx == r_cur);
  // A winner aborted in the same cycle it is picked is simply not sent.
  assign w_sel_ok    = w_any && !(abort_en && abort_idx == w_win);
  assign w_abort_cur = r_abort[r_cur] || (abort_en && abort_idx == r_cur);

  assign w_done    = (r_state == WAIT) && tx_done;
  assign w_err     = (r_state == WAIT) && !tx_done && tx_error;
  assign w_lost    = (r_state == WAIT) && !tx_done && !tx_error && arb_lost;
  assign w_outcome = w_done || w_err || w_lost;

`ifdef CAN_MBOX_RETRY_LIMIT_EN
  logic [7:0] r_retry [NUM_MB];

  assign w_retry_hit = w_err && (({1'b0, r_retry[r_cur]} + 9'd1) >= 9'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MB; i++) r_retry[i] <= '0;
    end else begin
      if (w_done || w_retry_hit)            r_retry[r_cur] <= '0;
      else if (w_err && r_retry[r_cur] != 8'hFF) r_retry[r_cur] <= r_retry[r_cur] + 8'd1;
      if (w_wr_ok) r_retry[wr_idx] <= '0;
    end
  end
`else
  assign w_retry_hit = 1'b0;
`endif

  assign w_release = w_done || w_retry_hit || (w_outcome && w_abort_cur);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|r_pending) w_state_nxt = SELECT;
      SELECT:  w_state_nxt = w_sel_ok ? REQ : IDLE;
      REQ:     w_state_nxt = WAIT;
      WAIT:    if (w_outcome) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mb_ide[wr_idx]    <= wr_ide;
      r_mb_rtr[wr_idx]    <= wr_rtr;
      r_mb_id_std[wr_idx] <= wr_id_std;
      r_mb_id_ext[wr_idx] <= wr_id_ext;
      r_mb_dlc[wr_idx]    <= wr_dlc;
      r_mb_data[wr_idx]   <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_abort   <= '0;
      r_cur     <= '0;
      r_evt     <= '0;
      r_wr_err  <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_ide     <= 1'b0;
      r_rtr     <= 1'b0;
      r_id_std  <= '0;
      r_id_ext  <= '0;
      r_dlc     <= '0;
      r_data    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_err <= wr_en && !w_wr_ok;
      r_done   <= w_done;
      r_fail   <= w_retry_hit && !w_abort_cur;
      if (r_state == SELECT && w_sel_ok) begin
        r_cur    <= w_win;
        r_ide    <= r_mb_ide[w_win];
        r_rtr    <= r_mb_rtr[w_win];
        r_id_std <= r_mb_id_std[w_win];
        r_id_ext <= r_mb_id_ext[w_win];
        r_dlc    <= r_mb_dlc[w_win];
        r_data   <= r_mb_data[w_win];
      end
      if (abort_en) begin
        if (w_busy && abort_idx == r_cur) r_abort[abort_idx]   <= 1'b1;
        else                              r_pending[abort_idx] <= 1'b0;
      end
      if (w_wr_ok) r_pending[wr_idx] <= 1'b1;
      if (w_outcome) begin
        r_abort[r_cur] <= 1'b0;
        if (w_release) r_pending[r_cur] <= 1'b0;
      end
      if (w_done || (w_retry_hit && !w_abort_cur)) r_evt <= r_cur;
    end
  end

  assign start_tx   = (r_state == REQ);
  assign ide        = r_ide;
  assign rtr        = r_rtr;
  assign id_std     = r_id_std;
  assign id_ext     = r_id_ext;
  assign dlc        = r_dlc;
  assign tx_data    = r_data;
  assign mb_pending = r_pending;
  assign wr_err     = r_wr_err;
  assign done_pulse = r_done;
  assign fail_pulse = r_fail;
  assign evt_idx    = r_evt;
endmodule

// File: tb/tb_can_tx_mailbox.sv
// Directed bench for can_tx_mailbox; honours CAN_MBOX_RETRY_LIMIT_EN when defined.
module tb_can_tx_mailbox;
  localparam int NUM_MB    = 4;
  localparam int MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_ide = 1'b0, wr_rtr = 1'b0;
  logic [1:0]  wr_idx = '0, abort_idx = '0;
  logic [10:0] wr_id_std = '0;
  logic [28:0] wr_id_ext = '0;
  logic [3:0]  wr_dlc = '0;
  logic [63:0] wr_data = '0;
  logic        abort_en = 1'b0;
  logic        tx_done = 1'b0, arb_lost = 1'b0, tx_error = 1'b0;
  logic        start_tx, ide, rtr, wr_err, done_pulse, fail_pulse;
  logic [10:0] id_std;
  logic [28:0] id_ext;
  logic [3:0]  dlc;
  logic [63:0] tx_data;
  logic [3:0]  mb_pending;
  logic [1:0]  evt_idx;

  int n_chk = 0, n_err = 0, n_start = 0;

  can_tx_mailbox #(.NUM_MB(NUM_MB), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_ide(wr_ide), .wr_rtr(wr_rtr),
    .wr_id_std(wr_id_std), .wr_id_ext(wr_id_ext), .wr_dlc(wr_dlc), .wr_data(wr_data),
    .abort_en(abort_en), .abort_idx(abort_idx),
    .start_tx(start_tx), .ide(ide), .rtr(rtr), .id_std(id_std), .id_ext(id_ext),
    .dlc(dlc), .tx_data(tx_data),
    .tx_done(tx_done), .arb_lost(arb_lost), .tx_error(tx_error),
    .mb_pending(mb_pending), .wr_err(wr_err),
    .done_pulse(done_pulse), .fail_pulse(fail_pulse), .evt_idx(evt_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (start_tx) n_start++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic i_ide, input logic i_rtr,
                    input logic [10:0] s, input logic [28:0] e,
                    input logic [3:0] d, input logic [63:0] dat);
    wr_en = 1'b1; wr_idx = idx; wr_ide = i_ide; wr_rtr = i_rtr;
    wr_id_std = s; wr_id_ext = e; wr_dlc = d; wr_data = dat;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic abort(input logic [1:0] idx);
    abort_en = 1'b1; abort_idx = idx;
    tick();
    abort_en = 1'b0;
  endtask

  // 0 = tx_done, 1 = arb_lost, 2 = tx_error
  task automatic pulse(input int kind);
    tx_done = (kind == 0); arb_lost = (kind == 1); tx_error = (kind == 2);
    tick();
    tx_done = 1'b0; arb_lost = 1'b0; tx_error = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && !start_tx; i++) tick();
    chk({tag, "_start"}, 64'(start_tx), 64'd1);
  endtask

  logic [1:0]  exp_idx [3] = '{2'd2, 2'd1, 2'd3};
  logic        exp_ide [3] = '{1'b0, 1'b0, 1'b1};
  logic        exp_rtr [3] = '{1'b0, 1'b1, 1'b0};
  logic [28:0] exp_key [3] = '{29'h100, 29'h100, 29'h04000000};

  initial begin
    int s;
    #1;
    chk("rst_start", 64'(start_tx), 0);
    chk("rst_pend",  64'(mb_pending), 0);
    chk("rst_flags", 64'({wr_err, done_pulse, fail_pulse}), 0);
    chk("rst_evt",   64'(evt_idx), 0);
    chk("rst_data",  tx_data, 0);
    chk("rst_id",    64'({ide, rtr, id_std, id_ext, dlc}), 0);
    #11 rst = 1'b0;
    tick();

    // single standard frame, latency and completion
    wr(2'd0, 0, 0, 11'h123, 0, 4'd4, 64'h44332211);
    chk("t21_pend", 64'(mb_pending), 64'h1);
    chk("t21_n1",   64'(start_tx), 0);
    tick();
    chk("t21_n2",   64'(start_tx), 0);
    tick();
    chk("t21_start", 64'(start_tx), 1);
    chk("t21_id",    64'(id_std), 64'h123);
    chk("t21_dlc",   64'(dlc), 4);
    chk("t21_data",  tx_data, 64'h44332211);
    tick();
    chk("t21_one",   64'(start_tx), 0);
    pulse(0);
    chk("t21_done",  64'(done_pulse), 1);
    chk("t21_evt",   64'(evt_idx), 0);
    chk("t21_pend0", 64'(mb_pending), 0);
    tick();
    chk("t21_dpls",  64'(done_pulse), 0);

    // priority order
    wr(2'd2, 0, 0, 11'h100, 0, 4'd1, 64'h2);
    wr(2'd1, 0, 1, 11'h100, 0, 4'd0, 64'h1);
    wr(2'd3, 1, 0, 11'h000, 29'h04000000, 4'd8, 64'h3);
    for (int k = 0; k < 3; k++) begin
      wait_start($sformatf("t22_%0d", k));
      chk($sformatf("t22_ide%0d", k), 64'(ide), 64'(exp_ide[k]));
      chk($sformatf("t22_rtr%0d", k), 64'(rtr), 64'(exp_rtr[k]));
      chk($sformatf("t22_id%0d", k), exp_ide[k] ? 64'(id_ext) : 64'(id_std), 64'(exp_key[k]));
      tick();
      pulse(0);
      chk($sformatf("t22_evt%0d", k), 64'({done_pulse, evt_idx}), 64'({1'b1, exp_idx[k]}));
    end
    chk("t22_pend", 64'(mb_pending), 0);

    // arbitration loss retries indefinitely
    s = n_start;
    wr(2'd1, 0, 0, 11'h200, 0, 4'd2, 64'hBEEF);
    for (int k = 0; k < 3; k++) begin
      wait_start($sformatf("t23_%0d", k));
      tick();
      pulse(1);
      chk($sformatf("t23_pend%0d", k), 64'(mb_pending), 64'h2);
      chk($sformatf("t23_pls%0d", k), 64'({done_pulse, fail_pulse}), 0);
    end
    wait_start("t23_3");
    tick();
    pulse(0);
    chk("t23_done",   64'({done_pulse, evt_idx}), 64'({1'b1, 2'd1}));
    chk("t23_starts", 64'(n_start - s), 4);

    // transmit errors
    wr(2'd1, 0, 0, 11'h300, 0, 4'd1, 64'h5);
    for (int k = 0; k < 3; k++) begin
      wait_start($sformatf("t24_%0d", k));
      tick();
      pulse(2);
`ifdef CAN_MBOX_RETRY_LIMIT_EN
      chk($sformatf("t24_fail%0d", k), 64'(fail_pulse), 64'(k == 2));
      chk($sformatf("t24_pend%0d", k), 64'(mb_pending), (k == 2) ? 64'h0 : 64'h2);
`else
      chk($sformatf("t24_fail%0d", k), 64'(fail_pulse), 0);
      chk($sformatf("t24_pend%0d", k), 64'(mb_pending), 64'h2);
`endif
    end
`ifdef CAN_MBOX_RETRY_LIMIT_EN
    chk("t24_evt", 64'(evt_idx), 1);
    s = n_start;
    repeat (6) tick();
    chk("t24_nostart", 64'(n_start - s), 0);
`else
    wait_start("t24_4th");
    tick();
    pulse(0);
    chk("t24_done", 64'({done_pulse, evt_idx}), 64'({1'b1, 2'd1}));
`endif

    // in-flight write rejection and aborts
    wr(2'd0, 0, 0, 11'h050, 0, 4'd2, 64'hAA);
    wait_start("t25");
    tick();
    wr(2'd0, 0, 0, 11'h7FF, 0, 4'd8, 64'hFF);
    chk("t25_wrerr", 64'(wr_err), 1);
    chk("t25_hold",  64'({id_std, dlc}), 64'({11'h050, 4'd2}));
    wr(2'd2, 0, 0, 11'h010, 0, 4'd1, 64'h1);
    chk("t25_wrok",  64'(wr_err), 0);
    chk("t25_p2",    64'(mb_pending), 64'h5);
    abort(2'd2);
    chk("t25_ab2",   64'(mb_pending), 64'h1);
    abort(2'd0);
    chk("t25_defer", 64'(mb_pending), 64'h1);
    pulse(1);
    chk("t25_clr",   64'(mb_pending), 0);
    chk("t25_nopls", 64'({done_pulse, fail_pulse}), 0);
    s = n_start;
    repeat (6) tick();
    chk("t25_idle",  64'(n_start - s), 0);

    // reset mid-WAIT
    wr(2'd1, 0, 0, 11'h321, 0, 4'd3, 64'h77);
    wait_start("t26");
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t26_rst_out", 64'({start_tx, mb_pending, wr_err, done_pulse, fail_pulse, evt_idx}), 0);
    chk("t26_rst_fld", 64'({ide, rtr, id_std, id_ext, dlc}), 0);
    #3 rst = 1'b0;
    s = n_start;
    pulse(0);
    chk("t26_ign", 64'(done_pulse), 0);
    repeat (6) tick();
    chk("t26_quiet", 64'(n_start - s), 0);
    wr(2'd1, 0, 0, 11'h321, 0, 4'd3, 64'h77);
    wait_start("t26_new");
    tick();
    pulse(0);
    chk("t26_done", 64'({done_pulse, evt_idx}), 64'({1'b1, 2'd1}));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
